// File: rtl/mesh_router_pkg.sv
// Shared definitions for the virtual-channel mesh router.
//   - Port index constants: N=0, E=1, S=2, W=3, PE=4
//   - NUM_PORTS / NUM_VCS
//   - route(): XY dimension-order output port selection
package mesh_router_pkg;

   localparam int NUM_PORTS = 5;
   localparam int NUM_VCS   = 2;

   localparam logic [2:0] PORT_N  = 3'd0;
   localparam logic [2:0] PORT_E  = 3'd1;
   localparam logic [2:0] PORT_S  = 3'd2;
   localparam logic [2:0] PORT_W  = 3'd3;
   localparam logic [2:0] PORT_PE = 3'd4;

   // route() takes coordinates zero-extended to this width, so COORD_W
   // may be anything up to 16 without changing the unsigned ordering.
   localparam int ROUTE_COORD_W = 16;
   typedef logic [ROUTE_COORD_W-1:0] coord_t;

   // X is resolved first, then Y; a flit addressed to this node goes to PE.
   function automatic logic [2:0] route(input coord_t dst_x, input coord_t dst_y,
                                        input coord_t my_x,  input coord_t my_y);
      if (dst_x > my_x)      route = PORT_E;
      else if (dst_x < my_x) route = PORT_W;
      else if (dst_y < my_y) route = PORT_N;
      else if (dst_y > my_y) route = PORT_S;
      else                   route = PORT_PE;
   endfunction

endpackage

// File: rtl/vc_fifo.sv
// Synchronous FIFO holding the flits of one input port on one virtual channel.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   push, din  : write din when push is high and the FIFO is not full
//   pop        : discard the head entry when pop is high and not empty
//   full/empty : occupancy flags
//   head       : oldest entry (valid only while empty is low)
module vc_fifo #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] din,
   output logic                  full,
   output logic                  empty,
   output logic [DATA_WIDTH-1:0] head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic                  do_push;
   logic                  do_pop;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
      return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= next_ptr(wr_ptr);
         end
         if (do_pop) rd_ptr <= next_ptr(rd_ptr);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (do_pop && !do_push) count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/mesh_router_vc.sv
// Five-port XY mesh router with two polarity-multiplexed virtual channels.
//   clk, reset : clock, synchronous active-high reset
//   polarity   : VC phase, 0 after reset, toggles every cycle
//   in_si/in_di/in_ri    : per-port input link (N,E,S,W,PE = 0..4)
//   out_so/out_do/out_ro : per-port output link
//
// Link handshake: a flit moves across a link in a cycle where send and
// ready are both high, on the VC equal to polarity. On the input side the
// upstream raises in_si with in_di and must hold both until in_ri is high
// in a cycle of the flit's VC. On the output side out_so already includes
// out_ro, so out_so high means the flit is taken at that edge.
//
// Each cycle the VC equal to polarity uses the external links while the
// other VC crosses the switch, so a given FIFO or output register is never
// filled and drained in the same cycle.
module mesh_router_vc
   import mesh_router_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int COORD_W    = 4,
   parameter int MY_X       = 0,
   parameter int MY_Y       = 0,
   parameter int DEPTH      = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   output logic                          polarity,
   input  logic [NUM_PORTS-1:0]          in_si,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_di,
   output logic [NUM_PORTS-1:0]          in_ri,
   output logic [NUM_PORTS-1:0]          out_so,
   output logic [NUM_PORTS*DATA_WIDTH-1:0] out_do,
   input  logic [NUM_PORTS-1:0]          out_ro
);

   // Queue index for (port, vc) pairs: port*NUM_VCS + vc.
   localparam int NQ = NUM_PORTS * NUM_VCS;

   logic                  ext_vc;
   logic                  int_vc;
   logic [NQ-1:0]         push;
   logic [NQ-1:0]         pop;
   logic [NQ-1:0]         full;
   logic [NQ-1:0]         empty;
   logic [DATA_WIDTH-1:0] head [NQ];
   logic [2:0]            dest [NQ];
   logic [NQ-1:0]         obuf_valid;
   logic [DATA_WIDTH-1:0] obuf_data [NQ];
   logic [NQ-1:0]         gnt;
   logic [3*NQ-1:0]       gnt_win;

   assign ext_vc = polarity;
   assign int_vc = ~polarity;

   always_ff @(posedge clk) begin
      if (reset) polarity <= 1'b0;
      else       polarity <= ~polarity;
   end

   // Per input port: link side and one FIFO per VC.
   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
      assign in_ri[p] = ext_vc ? !full[p*NUM_VCS+1] : !full[p*NUM_VCS];

      for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
         localparam int I = p*NUM_VCS + v;
         logic pop_any;

         assign push[I] = in_si[p] && in_ri[p] && (ext_vc == 1'(v));

         vc_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[I]),
            .pop   (pop[I]),
            .din   (in_di[p*DATA_WIDTH +: DATA_WIDTH]),
            .full  (full[I]),
            .empty (empty[I]),
            .head  (head[I])
         );

         assign dest[I] = route(coord_t'(head[I][2*COORD_W-1:COORD_W]),
                                coord_t'(head[I][COORD_W-1:0]),
                                coord_t'(MY_X), coord_t'(MY_Y));

         // Popped when any output on this VC chose this input.
         always_comb begin
            pop_any = 1'b0;
            for (int q = 0; q < NUM_PORTS; q++) begin
               if (gnt[q*NUM_VCS+v] && (gnt_win[3*(q*NUM_VCS+v) +: 3] == 3'(p)))
                  pop_any = 1'b1;
            end
         end
         assign pop[I] = pop_any;
      end
   end

   // Per output port / VC: round-robin arbiter plus output register.
   for (genvar q = 0; q < NUM_PORTS; q++) begin : g_out
      for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
         localparam int I = q*NUM_VCS + v;
         logic [NUM_PORTS-1:0]  req;
         logic                  found;
         logic [2:0]            win;
         logic [2:0]            idx;
         logic [3:0]            sum;
         logic [DATA_WIDTH-1:0] win_data;
         logic                  valid_r;
         logic [DATA_WIDTH-1:0] data_r;
         logic [2:0]            rr_r;

         always_comb begin
            req      = '0;
            found    = 1'b0;
            win      = 3'd0;
            idx      = 3'd0;
            sum      = 4'd0;
            win_data = '0;
            // Only the switching VC arbitrates, and only into an empty register.
            for (int p = 0; p < NUM_PORTS; p++)
               req[p] = (int_vc == 1'(v)) && !valid_r &&
                        !empty[p*NUM_VCS+v] && (dest[p*NUM_VCS+v] == 3'(q));
            // Search starts at rr_r and wraps 4 -> 0.
            for (int k = 0; k < NUM_PORTS; k++) begin
               sum = {1'b0, rr_r} + 4'(k);
               idx = (sum >= 4'(NUM_PORTS)) ? 3'(sum - 4'(NUM_PORTS)) : sum[2:0];
               if (!found && req[idx]) begin
                  found = 1'b1;
                  win   = idx;
               end
            end
            for (int p = 0; p < NUM_PORTS; p++)
               if (win == 3'(p)) win_data = head[p*NUM_VCS+v];
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               valid_r <= 1'b0;
               data_r  <= '0;
               rr_r    <= 3'd0;
            end else if (found) begin
               valid_r <= 1'b1;
               data_r  <= win_data;
               rr_r    <= (win == 3'(NUM_PORTS-1)) ? 3'd0 : win + 3'd1;
            end else if ((ext_vc == 1'(v)) && out_so[q]) begin
               valid_r <= 1'b0;
            end
         end

         assign gnt[I]              = found;
         assign gnt_win[3*I +: 3]   = win;
         assign obuf_valid[I]       = valid_r;
         assign obuf_data[I]        = data_r;
      end

      assign out_so[q] = (ext_vc ? obuf_valid[q*NUM_VCS+1] : obuf_valid[q*NUM_VCS]) && out_ro[q];
      assign out_do[q*DATA_WIDTH +: DATA_WIDTH] =
         ext_vc ? obuf_data[q*NUM_VCS+1] : obuf_data[q*NUM_VCS];
   end

endmodule

// File: tb/tb_mesh_router_vc.sv
// Directed bench for mesh_router_vc at node (1,1): reset/idle, single-flit
// routes, three-way contention on E, backpressure with VC isolation, and
// reset while flits are buffered.
module tb_mesh_router_vc;

   localparam int DW   = 64;
   localparam int P_N  = 0;
   localparam int P_E  = 1;
   localparam int P_S  = 2;
   localparam int P_W  = 3;
   localparam int P_PE = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            polarity;
   logic [4:0]      in_si;
   logic [5*DW-1:0] in_di;
   logic [4:0]      in_ri;
   logic [4:0]      out_so;
   logic [5*DW-1:0] out_do;
   logic [4:0]      out_ro;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] exp_n_q[$];
   logic [DW-1:0] vc0_q[$];
   logic [DW-1:0] vc1_q[$];

   mesh_router_vc #(
      .DATA_WIDTH (DW),
      .COORD_W    (4),
      .MY_X       (1),
      .MY_Y       (1),
      .DEPTH      (2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .polarity (polarity),
      .in_si    (in_si),
      .in_di    (in_di),
      .in_ri    (in_ri),
      .out_so   (out_so),
      .out_do   (out_do),
      .out_ro   (out_ro)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [DW-1:0] mk_flit(input logic [7:0] dst, input logic [15:0] tag);
      return {8'hA5, 32'h5A5A_0000, tag, dst};
   endfunction

   function automatic logic [DW-1:0] od(input int q);
      return out_do[q*DW +: DW];
   endfunction

   // ---------------- driver tasks ----------------
   // Returns at a falling edge with reset released; that cycle has polarity 0.
   task automatic apply_reset();
      @(negedge clk);
      reset  = 1'b1;
      in_si  = '0;
      in_di  = '0;
      out_ro = '1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic set_flit(input int port, input logic [DW-1:0] flit);
      in_di[port*DW +: DW] = flit;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic exp_pol;
      apply_reset();
      for (int c = 0; c < 6; c++) begin
         #1;
         exp_pol = (c % 2) == 1;
         checks++;
         if (polarity !== exp_pol) begin
            errors++;
            $display("FAIL reset_polarity c=%0d: got %0b want %0b", c, polarity, exp_pol);
         end
         checks++;
         if (in_ri !== 5'b11111) begin
            errors++;
            $display("FAIL reset_in_ri c=%0d: got %b want 11111", c, in_ri);
         end
         checks++;
         if (out_so !== 5'b00000) begin
            errors++;
            $display("FAIL reset_out_so c=%0d: got %b want 00000", c, out_so);
         end
         checks++;
         if (out_do !== '0) begin
            errors++;
            $display("FAIL reset_out_do c=%0d: got %h want 0", c, out_do);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_single_routes();
      int            src  [5] = '{P_W, P_N, P_E, P_S, P_PE};
      logic [7:0]    dst  [5] = '{8'h21, 8'h11, 8'h10, 8'h12, 8'h01};
      int            dport[5] = '{P_E, P_PE, P_N, P_S, P_W};
      logic [DW-1:0] flit;
      logic [4:0]    exp_so;
      for (int i = 0; i < 5; i++) begin
         apply_reset();
         flit = mk_flit(dst[i], 16'h0100 + 16'(i));
         exp_so = 5'b00001 << dport[i];
         in_si[src[i]] = 1'b1;
         set_flit(src[i], flit);
         #1;
         checks++;
         if (in_ri[src[i]] !== 1'b1) begin
            errors++;
            $display("FAIL single_accept dst=%h: in_ri got %b want 1", dst[i], in_ri[src[i]]);
         end
         @(negedge clk);
         in_si = '0;
         #1;
         checks++;
         if (out_so !== 5'b00000) begin
            errors++;
            $display("FAIL single_early dst=%h: out_so got %b want 00000", dst[i], out_so);
         end
         @(negedge clk);
         #1;
         checks++;
         if (out_so !== exp_so) begin
            errors++;
            $display("FAIL single_port dst=%h: out_so got %b want %b", dst[i], out_so, exp_so);
         end
         checks++;
         if (od(dport[i]) !== flit) begin
            errors++;
            $display("FAIL single_data dst=%h: got %h want %h", dst[i], od(dport[i]), flit);
         end
         @(negedge clk);
         #1;
         checks++;
         if (out_so !== 5'b00000) begin
            errors++;
            $display("FAIL single_after dst=%h: out_so got %b want 00000", dst[i], out_so);
         end
      end
   endtask

   // N, S, PE all target E on VC0, two rounds; pointer starts at 0.
   task automatic test_contention();
      logic [DW-1:0] exp;
      apply_reset();
      exp_q.delete();
      for (int r = 0; r < 2; r++) begin
         exp_q.push_back(mk_flit(8'h21, 16'h0200 + 16'(r*16 + P_N)));
         exp_q.push_back(mk_flit(8'h21, 16'h0200 + 16'(r*16 + P_S)));
         exp_q.push_back(mk_flit(8'h21, 16'h0200 + 16'(r*16 + P_PE)));
      end
      for (int c = 0; c < 16; c++) begin
         in_si = '0;
         if (c == 0 || c == 2) begin
            set_flit(P_N,  mk_flit(8'h21, 16'h0200 + 16'((c/2)*16 + P_N)));
            set_flit(P_S,  mk_flit(8'h21, 16'h0200 + 16'((c/2)*16 + P_S)));
            set_flit(P_PE, mk_flit(8'h21, 16'h0200 + 16'((c/2)*16 + P_PE)));
            in_si = 5'b10101;
         end
         #1;
         if (c == 0 || c == 2) begin
            checks++;
            if (in_ri !== 5'b11111) begin
               errors++;
               $display("FAIL contention_accept c=%0d: in_ri got %b want 11111", c, in_ri);
            end
         end
         if (out_so !== 5'b00000) begin
            checks++;
            if (out_so !== 5'b00010) begin
               errors++;
               $display("FAIL contention_port c=%0d: out_so got %b want 00010", c, out_so);
            end else if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL contention_extra c=%0d: got %h want nothing", c, od(P_E));
            end else begin
               exp = exp_q.pop_front();
               if (od(P_E) !== exp) begin
                  errors++;
                  $display("FAIL contention_order c=%0d: got %h want %h", c, od(P_E), exp);
               end
            end
         end
         @(negedge clk);
      end
      in_si = '0;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL contention_missing: got %0d left want 0", exp_q.size());
      end
   endtask

   // E blocked on VC0 while W streams VC0 to E and VC1 to N.
   task automatic test_backpressure();
      logic          exp_ri;
      logic          vc0_now;
      logic [DW-1:0] exp;
      apply_reset();
      exp_q.delete();
      exp_n_q.delete();
      vc0_q.delete();
      vc1_q.delete();
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(mk_flit(8'h21, 16'h0300 + 16'(i)));
         vc0_q.push_back(mk_flit(8'h21, 16'h0300 + 16'(i)));
         exp_n_q.push_back(mk_flit(8'h10, 16'h0400 + 16'(i)));
         vc1_q.push_back(mk_flit(8'h10, 16'h0400 + 16'(i)));
      end
      out_ro = 5'b11101;
      for (int c = 0; c < 30; c++) begin
         if (c == 12) out_ro = 5'b11111;
         in_si   = '0;
         vc0_now = (c % 2) == 0;
         if (vc0_now && vc0_q.size() > 0) begin
            in_si[P_W] = 1'b1;
            set_flit(P_W, vc0_q[0]);
         end
         if (!vc0_now && vc1_q.size() > 0) begin
            in_si[P_W] = 1'b1;
            set_flit(P_W, vc1_q[0]);
         end
         #1;
         if (vc0_now && c <= 12) begin
            exp_ri = (c <= 4);
            checks++;
            if (in_ri[P_W] !== exp_ri) begin
               errors++;
               $display("FAIL bp_vc0_ready c=%0d: got %b want %b", c, in_ri[P_W], exp_ri);
            end
         end
         if (!vc0_now && c <= 9) begin
            checks++;
            if (in_ri[P_W] !== 1'b1) begin
               errors++;
               $display("FAIL bp_vc1_ready c=%0d: got %b want 1", c, in_ri[P_W]);
            end
         end
         if (in_si[P_W] && in_ri[P_W]) begin
            if (vc0_now) void'(vc0_q.pop_front());
            else         void'(vc1_q.pop_front());
         end
         if (out_so[P_E]) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL bp_e_extra c=%0d: got %h want nothing", c, od(P_E));
            end else begin
               exp = exp_q.pop_front();
               if (od(P_E) !== exp) begin
                  errors++;
                  $display("FAIL bp_e_data c=%0d: got %h want %h", c, od(P_E), exp);
               end
            end
         end
         if (out_so[P_N]) begin
            checks++;
            if (exp_n_q.size() == 0) begin
               errors++;
               $display("FAIL bp_n_extra c=%0d: got %h want nothing", c, od(P_N));
            end else begin
               exp = exp_n_q.pop_front();
               if (od(P_N) !== exp) begin
                  errors++;
                  $display("FAIL bp_n_data c=%0d: got %h want %h", c, od(P_N), exp);
               end
            end
         end
         if ((out_so & 5'b11100) != 5'b00000) begin
            checks++;
            errors++;
            $display("FAIL bp_stray c=%0d: out_so got %b want only E/N bits", c, out_so);
         end
         if (c == 10) begin
            checks++;
            if (exp_n_q.size() != 0 || exp_q.size() != 4) begin
               errors++;
               $display("FAIL bp_isolation: left N=%0d E=%0d want N=0 E=4", exp_n_q.size(), exp_q.size());
            end
         end
         @(negedge clk);
      end
      in_si = '0;
      checks++;
      if (exp_q.size() != 0 || exp_n_q.size() != 0 || vc0_q.size() != 0) begin
         errors++;
         $display("FAIL bp_drain: left E=%0d N=%0d unsent=%0d want 0", exp_q.size(), exp_n_q.size(), vc0_q.size());
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      set_flit(P_N,  mk_flit(8'h21, 16'h0501));
      set_flit(P_S,  mk_flit(8'h21, 16'h0502));
      set_flit(P_PE, mk_flit(8'h21, 16'h0503));
      in_si = 5'b10101;
      @(negedge clk);
      in_si = '0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (out_so !== 5'b00000) begin
         errors++;
         $display("FAIL midreset_out_so: got %b want 00000", out_so);
      end
      checks++;
      if (in_ri !== 5'b11111) begin
         errors++;
         $display("FAIL midreset_in_ri: got %b want 11111", in_ri);
      end
      checks++;
      if (polarity !== 1'b0) begin
         errors++;
         $display("FAIL midreset_polarity: got %b want 0", polarity);
      end
      checks++;
      if (out_do !== '0) begin
         errors++;
         $display("FAIL midreset_out_do: got %h want 0", out_do);
      end
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if (out_so !== 5'b00000) begin
            errors++;
            $display("FAIL midreset_ghost c=%0d: out_so got %b want 00000", c, out_so);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset  = 1'b1;
      in_si  = '0;
      in_di  = '0;
      out_ro = '1;
      test_reset();
      test_single_routes();
      test_contention();
      test_backpressure();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
